// File: rtl/gpsdc_pkg.sv
// Shared types and widths for the GPS distance calculator fix streamer.
package gpsdc_pkg;

    localparam int COORD_W = 24;
    localparam int D_W     = 40;
    localparam int A_W     = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        WAIT_V = 2'd2
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] lon;
        logic [COORD_W-1:0] lat;
    } fix_t;

endpackage

// File: rtl/gpsdc_fix_fifo.sv
// Synchronous FIFO holding packed fix_t entries between the upstream source
// and the issue FSM. DEPTH must be a power of two so pointers wrap naturally.
module gpsdc_fix_fifo
    import gpsdc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [2*COORD_W-1:0]   wdata,
    output logic [2*COORD_W-1:0]   rdata,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [2*COORD_W-1:0] mem_q [DEPTH];
    logic [2*COORD_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 do_push_s;
    logic                 do_pop_s;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == (AW+1)'(0));
    assign rdata     = mem_q[rd_ptr_q];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gpsdc_fix_streamer.sv
// Feeds buffered GPS fixes to the distance calculator one DEN strobe at a
// time and captures its D/a results into a single-entry handshake slot.
// Optional WAIT_V timeout enabled by defining GPSDC_STREAM_TIMEOUT_EN.
module gpsdc_fix_streamer
    import gpsdc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int FIRST_GAP = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_lon,
    input  logic [COORD_W-1:0] in_lat,
    input  logic               track_clr,
    output logic               DEN,
    output logic [COORD_W-1:0] LON_IN,
    output logic [COORD_W-1:0] LAT_IN,
    input  logic               Valid,
    input  logic [D_W-1:0]     D,
    input  logic [A_W-1:0]     a,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [D_W-1:0]     res_d,
    output logic [A_W-1:0]     res_a,
    output logic [7:0]         res_seq,
    output logic               res_timeout
);

    // One down-counter serves both the post-first-fix gap and the Valid
    // timeout, so it is sized for the larger of the two.
    localparam int CNT_MAX = (FIRST_GAP > TIMEOUT) ? FIRST_GAP : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] GAP_INIT = CW'(FIRST_GAP - 1);
`ifdef GPSDC_STREAM_TIMEOUT_EN
    localparam logic [CW-1:0] TO_INIT  = CW'(TIMEOUT - 1);
`endif

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 first_flag_q, first_flag_d;
    logic                 clr_pend_q, clr_pend_d;
    logic                 den_q, den_d;
    logic [COORD_W-1:0]   lon_in_q, lon_in_d;
    logic [COORD_W-1:0]   lat_in_q, lat_in_d;
    logic                 res_valid_q, res_valid_d;
    logic [D_W-1:0]       res_d_q, res_d_d;
    logic [A_W-1:0]       res_a_q, res_a_d;
    logic [7:0]           res_seq_q, res_seq_d;
    logic [7:0]           seq_q, seq_d;
    logic                 first_eff_s;
    logic                 pop_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [2*COORD_W-1:0] fifo_rdata_s;
    fix_t                 head_s;
`ifdef GPSDC_STREAM_TIMEOUT_EN
    logic                 res_timeout_q, res_timeout_d;
`endif

    gpsdc_fix_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid & ~fifo_full_s),
        .pop     (pop_s),
        .wdata   ({in_lon, in_lat}),
        .rdata   (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign head_s    = fifo_rdata_s;
    assign in_ready  = ~fifo_full_s;
    assign DEN       = den_q;
    assign LON_IN    = lon_in_q;
    assign LAT_IN    = lat_in_q;
    assign res_valid = res_valid_q;
    assign res_d     = res_d_q;
    assign res_a     = res_a_q;
    assign res_seq   = res_seq_q;
`ifdef GPSDC_STREAM_TIMEOUT_EN
    assign res_timeout = res_timeout_q;
`else
    assign res_timeout = 1'b0;
`endif

    // Issue/wait FSM next-state and result slot update.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        first_flag_d = first_flag_q;
        clr_pend_d   = clr_pend_q | track_clr;
        den_d        = 1'b0;
        lon_in_d     = lon_in_q;
        lat_in_d     = lat_in_q;
        res_d_d      = res_d_q;
        res_a_d      = res_a_q;
        res_seq_d    = res_seq_q;
        seq_d        = seq_q;
        first_eff_s  = first_flag_q;
        pop_s        = 1'b0;
`ifdef GPSDC_STREAM_TIMEOUT_EN
        res_timeout_d = res_timeout_q;
`endif
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end

        case (state_q)
            IDLE: begin
                // A pending track clear takes effect before this cycle's issue.
                first_eff_s  = first_flag_q | clr_pend_q;
                first_flag_d = first_eff_s;
                clr_pend_d   = track_clr;
                if (!fifo_empty_s && !res_valid_q) begin
                    pop_s    = 1'b1;
                    den_d    = 1'b1;
                    lon_in_d = head_s.lon;
                    lat_in_d = head_s.lat;
                    if (first_eff_s) begin
                        first_flag_d = 1'b0;
                        cnt_d        = GAP_INIT;
                        state_d      = GAP;
                    end else begin
`ifdef GPSDC_STREAM_TIMEOUT_EN
                        cnt_d   = TO_INIT;
`endif
                        state_d = WAIT_V;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_q == CW'(0)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_V: begin
                // Valid wins over an expiry landing on the same cycle.
                if (Valid) begin
                    res_valid_d = 1'b1;
                    res_d_d     = D;
                    res_a_d     = a;
                    res_seq_d   = seq_q;
                    seq_d       = seq_q + 8'd1;
`ifdef GPSDC_STREAM_TIMEOUT_EN
                    res_timeout_d = 1'b0;
`endif
                    state_d     = IDLE;
                end
`ifdef GPSDC_STREAM_TIMEOUT_EN
                else if (cnt_q == CW'(0)) begin
                    res_valid_d   = 1'b1;
                    res_d_d       = '0;
                    res_a_d       = '0;
                    res_seq_d     = seq_q;
                    seq_d         = seq_q + 8'd1;
                    res_timeout_d = 1'b1;
                    cnt_d         = GAP_INIT;
                    state_d       = GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`else
                else begin
                    state_d = WAIT_V;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            first_flag_q <= 1'b1;
            clr_pend_q   <= 1'b0;
            den_q        <= 1'b0;
            lon_in_q     <= '0;
            lat_in_q     <= '0;
            res_valid_q  <= 1'b0;
            res_d_q      <= '0;
            res_a_q      <= '0;
            res_seq_q    <= 8'd0;
            seq_q        <= 8'd0;
`ifdef GPSDC_STREAM_TIMEOUT_EN
            res_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            first_flag_q <= first_flag_d;
            clr_pend_q   <= clr_pend_d;
            den_q        <= den_d;
            lon_in_q     <= lon_in_d;
            lat_in_q     <= lat_in_d;
            res_valid_q  <= res_valid_d;
            res_d_q      <= res_d_d;
            res_a_q      <= res_a_d;
            res_seq_q    <= res_seq_d;
            seq_q        <= seq_d;
`ifdef GPSDC_STREAM_TIMEOUT_EN
            res_timeout_q <= res_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_gpsdc_fix_streamer.sv
// Directed bench for gpsdc_fix_streamer: first-fix gap, pairing, result
// backpressure, FIFO full, track clear, stray Valid and mid-run reset.
// With GPSDC_STREAM_TIMEOUT_EN defined it also exercises the Valid timeout.
module tb_gpsdc_fix_streamer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_lon;
    logic [23:0] in_lat;
    logic        track_clr;
    logic        DEN;
    logic [23:0] LON_IN;
    logic [23:0] LAT_IN;
    logic        Valid;
    logic [39:0] D;
    logic [63:0] a;
    logic        res_valid;
    logic        res_ready;
    logic [39:0] res_d;
    logic [63:0] res_a;
    logic [7:0]  res_seq;
    logic        res_timeout;

    int total = 0;
    int bad   = 0;
    int hits;

    gpsdc_fix_streamer #(.DEPTH(4), .FIRST_GAP(16), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_lon      (in_lon),
        .in_lat      (in_lat),
        .track_clr   (track_clr),
        .DEN         (DEN),
        .LON_IN      (LON_IN),
        .LAT_IN      (LAT_IN),
        .Valid       (Valid),
        .D           (D),
        .a           (a),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_d       (res_d),
        .res_a       (res_a),
        .res_seq     (res_seq),
        .res_timeout (res_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic valid_pulse(input logic [39:0] dv, input logic [63:0] av);
        Valid = 1'b1; D = dv; a = av;
        tick();
        Valid = 1'b0;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_lon = '0; in_lat = '0;
        track_clr = 1'b0; Valid = 1'b0; D = '0; a = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_den", DEN, 1'b0);
        check("rst_lon", LON_IN, 24'h0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_seq", res_seq, 8'd0);
        check("rst_res_timeout", res_timeout, 1'b0);
        reset_n = 1'b1;
        tick();

        // Stray Valid while idle is ignored.
        Valid = 1'b1; D = 40'h123; a = 64'h456;
        tick(); tick();
        Valid = 1'b0;
        check("stray_valid_idle", res_valid, 1'b0);

        // Single track: first fix, 16-cycle gap, second fix, result.
        in_valid = 1'b1; in_lon = 24'h78_0000; in_lat = 24'h19_0000;
        tick();
        check("den_latency_e0", DEN, 1'b0);
        in_lon = 24'h78_1000; in_lat = 24'h19_0800;
        tick();
        in_valid = 1'b0;
        check("den1", DEN, 1'b1);
        check("den1_lon", LON_IN, 24'h78_0000);
        check("den1_lat", LAT_IN, 24'h19_0000);
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (DEN) hits++;
        end
        check("gap_quiet", hits, 0);
        tick();
        check("den2", DEN, 1'b1);
        check("den2_lon", LON_IN, 24'h78_1000);
        check("den2_lat", LAT_IN, 24'h19_0800);
        tick();
        check("den_one_cycle", DEN, 1'b0);
        repeat (10) tick();
        check("no_result_yet", res_valid, 1'b0);
        valid_pulse(40'h12345, 64'hABC);
        check("r0_valid", res_valid, 1'b1);
        check("r0_d", res_d, 40'h12345);
        check("r0_a", res_a, 64'hABC);
        check("r0_seq", res_seq, 8'd0);
        check("r0_timeout", res_timeout, 1'b0);

        // Backpressure: result held, FIFO fills, fifth fix is dropped.
        hits = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_lon = 24'h01_0000 + 24'(k << 16); in_lat = 24'h02_0000;
            tick();
            if (DEN) hits++;
            if (k == 2) check("in_ready_after3", in_ready, 1'b1);
        end
        check("in_ready_full", in_ready, 1'b0);
        in_lon = 24'h0E_0000;
        tick(); if (DEN) hits++;
        tick(); if (DEN) hits++;
        in_valid = 1'b0;
        check("full_hold", in_ready, 1'b0);
        check("no_den_backpressure", hits, 0);
        check("res_held", res_valid, 1'b1);

        release_result();
        check("res_cleared", res_valid, 1'b0);
        check("no_den_on_release", DEN, 1'b0);
        tick();
        check("denA", DEN, 1'b1);
        check("denA_lon", LON_IN, 24'h01_0000);
        check("in_ready_after_pop", in_ready, 1'b1);
        valid_pulse(40'h2, 64'h22);
        check("rA_seq", res_seq, 8'd1);
        check("rA_d", res_d, 40'h2);

        // track_clr while waiting on B: B completes, C starts a new track.
        release_result();
        tick();
        check("denB_lon", LON_IN, 24'h02_0000);
        track_clr = 1'b1;
        tick();
        track_clr = 1'b0;
        valid_pulse(40'h3, 64'h33);
        check("rB_valid", res_valid, 1'b1);
        check("rB_seq", res_seq, 8'd2);
        check("rB_d", res_d, 40'h3);
        release_result();
        tick();
        check("denC", DEN, 1'b1);
        check("denC_lon", LON_IN, 24'h03_0000);
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (DEN || res_valid) hits++;
        end
        check("gap_after_clr", hits, 0);
        tick();
        check("denD", DEN, 1'b1);
        check("denD_lon", LON_IN, 24'h04_0000);
        valid_pulse(40'h4, 64'h44);
        check("rD_seq", res_seq, 8'd3);
        release_result();
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DEN) hits++;
        end
        check("overflow_dropped", hits, 0);

        // Reset during WAIT_V with one fix still queued.
        in_valid = 1'b1; in_lon = 24'h20_0000; in_lat = 24'h05_0000;
        tick();
        in_lon = 24'h21_0000;
        tick();
        in_valid = 1'b0;
        check("denE_lon", LON_IN, 24'h20_0000);
        tick(); tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_den", DEN, 1'b0);
        check("mrst_lon", LON_IN, 24'h0);
        check("mrst_lat", LAT_IN, 24'h0);
        check("mrst_in_ready", in_ready, 1'b1);
        check("mrst_res_valid", res_valid, 1'b0);
        check("mrst_res_seq", res_seq, 8'd0);
        check("mrst_res_d", res_d, 40'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        in_valid = 1'b1; in_lon = 24'h30_0000; in_lat = 24'h06_0000;
        tick();
        in_valid = 1'b0;
        tick();
        check("denG", DEN, 1'b1);
        check("denG_lon", LON_IN, 24'h30_0000);
        hits = 0;
        in_valid = 1'b1; in_lon = 24'h31_0000;
        tick();
        in_valid = 1'b0;
        if (DEN) hits++;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (DEN) hits++;
        end
        check("gap_after_reset", hits, 0);
        tick();
        check("denH_lon", LON_IN, 24'h31_0000);
        valid_pulse(40'h5, 64'h55);
        check("rH_valid", res_valid, 1'b1);
        check("rH_seq", res_seq, 8'd0);
        check("rH_d", res_d, 40'h5);

`ifdef GPSDC_STREAM_TIMEOUT_EN
        // Timeout: no Valid ever arrives for fix I.
        release_result();
        in_valid = 1'b1; in_lon = 24'h40_0000;
        tick();
        in_valid = 1'b0;
        tick();
        check("denI", DEN, 1'b1);
        hits = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (res_valid) hits++;
        end
        check("to_not_early", hits, 0);
        tick();
        check("to_valid", res_valid, 1'b1);
        check("to_flag", res_timeout, 1'b1);
        check("to_d", res_d, 40'h0);
        check("to_a", res_a, 64'h0);
        check("to_seq", res_seq, 8'd1);
        release_result();
        in_valid = 1'b1; in_lon = 24'h41_0000;
        tick();
        in_valid = 1'b0;
        hits = 0;
        for (int i = 0; i < 40 && hits == 0; i++) begin
            tick();
            if (DEN) hits = 1;
        end
        check("denJ_seen", hits, 1);
        repeat (63) tick();
        valid_pulse(40'h6, 64'h66);
        check("v63_valid", res_valid, 1'b1);
        check("v63_flag", res_timeout, 1'b0);
        check("v63_d", res_d, 40'h6);
        check("v63_seq", res_seq, 8'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
